// File: rtl/cache_tag_ctrl_pkg.sv
// Shared widths, status-word bit positions and controller states for the
// four-way cache tag controller.
package cache_pkg;
   localparam int TAG_W    = 11;
   localparam int LINE_W   = 10;
   localparam int WAYS     = 4;
   localparam int WAY_W    = 2;
   localparam int STAT_W   = 14;
   localparam int ADDR_W   = 23;
   localparam int MEM_AW   = TAG_W + LINE_W;
   localparam int CNT_W    = 16;
   localparam int TAG_LSB  = 12;
   localparam int LINE_LSB = 2;

   localparam int INV   = 13;
   localparam int DIRTY = 12;
   localparam int LAST  = 11;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOOKUP    = 3'd1,
      COMPARE   = 3'd2,
      WRITEBACK = 3'd3,
      REFILL    = 3'd4,
      UPDATE    = 3'd5,
      RESPOND   = 3'd6
   } state_t;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value,
                                               input logic [CNT_W-1:0] limit);
      return (value >= limit) ? limit : value + 16'd1;
   endfunction
endpackage

// File: rtl/cache_tag_ctrl_if.sv
// CPU-side request/response channel of the cache tag controller.
interface cache_tag_ctrl_if;
   import cache_pkg::*;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic              resp_valid;
   logic              resp_hit;
   logic [WAY_W-1:0]  resp_way;

   modport master (output req_valid, req_write, req_addr,
                   input  req_ready, resp_valid, resp_hit, resp_way);
   modport slave  (input  req_valid, req_write, req_addr,
                   output req_ready, resp_valid, resp_hit, resp_way);
endinterface

// File: rtl/cache_tag_ctrl_victim_sel.sv
// Victim priority encoder: lowest invalid way, else lowest way not marked
// last-used, else way 0. Also returns the chosen way's status word.
module cache_victim_sel
   import cache_pkg::*;
(
   input  logic [WAYS-1:0][STAT_W-1:0] statusWords,
   output logic [WAY_W-1:0]            victimWay,
   output logic [STAT_W-1:0]           victimStatus
);
   // Fixed-priority victim choice.
   always_comb begin
      victimWay = 2'd0;
      if (statusWords[0][INV]) begin
         victimWay = 2'd0;
      end else if (statusWords[1][INV]) begin
         victimWay = 2'd1;
      end else if (statusWords[2][INV]) begin
         victimWay = 2'd2;
      end else if (statusWords[3][INV]) begin
         victimWay = 2'd3;
      end else if (!statusWords[0][LAST]) begin
         victimWay = 2'd0;
      end else if (!statusWords[1][LAST]) begin
         victimWay = 2'd1;
      end else if (!statusWords[2][LAST]) begin
         victimWay = 2'd2;
      end else if (!statusWords[3][LAST]) begin
         victimWay = 2'd3;
      end else begin
         victimWay = 2'd0;
      end
   end

   assign victimStatus = statusWords[victimWay];
endmodule

// File: rtl/cache_tag_ctrl.sv
// Four-way cache tag controller: tag lookup, hit/miss decision, dirty
// write-back and refill through the next level, and tag-bank update.
module cache_tag_ctrl
   import cache_pkg::*;
#(
   parameter logic [CNT_W-1:0] CNT_SAT = 16'hFFFF
) (
   input  logic               CLK,
   input  logic               clear,
   cache_tag_ctrl_if.slave    cpu,
   input  logic [STAT_W-1:0]  Tag1,
   input  logic [STAT_W-1:0]  Tag2,
   input  logic [STAT_W-1:0]  Tag3,
   input  logic [STAT_W-1:0]  Tag4,
   output logic [LINE_W-1:0]  tb_line,
   output logic [TAG_W-1:0]   tb_tag,
   output logic [WAY_W-1:0]   tb_way,
   output logic               tb_en_n,
   output logic               tb_we_n,
   output logic               tb_replace,
   output logic               tb_dirty,
   output logic               mem_req,
   output logic               mem_we,
   output logic [MEM_AW-1:0]  mem_addr,
   input  logic               mem_ack,
   output logic [CNT_W-1:0]   hit_count,
   output logic [CNT_W-1:0]   miss_count
);
   state_t                      state_r, stateNext_s;
   logic [TAG_W-1:0]            reqTag_r, victimTag_r;
   logic [LINE_W-1:0]           reqLine_r;
   logic                        reqWrite_r, wasHit_r;
   logic [WAY_W-1:0]            way_r;
   logic [CNT_W-1:0]            hitCount_r, missCount_r;
   logic [WAYS-1:0][STAT_W-1:0] status_s;
   logic [WAYS-1:0]             match_s;
   logic                        hit_s;
   logic [WAY_W-1:0]            hitWay_s, victimWay_s;
   logic [STAT_W-1:0]           victimStatus_s;
   logic                        victimDirty_s;

   assign status_s      = {Tag4, Tag3, Tag2, Tag1};
   assign victimDirty_s = !victimStatus_s[INV] && victimStatus_s[DIRTY];
   assign hit_count     = hitCount_r;
   assign miss_count    = missCount_r;

   cache_victim_sel u_victimSel (
      .statusWords  (status_s),
      .victimWay    (victimWay_s),
      .victimStatus (victimStatus_s)
   );

   // Per-way tag match and lowest-index hit selection.
   always_comb begin
      match_s = {WAYS{1'b0}};
      for (int i = 0; i < WAYS; i++) begin
         match_s[i] = !status_s[i][INV] && (status_s[i][TAG_W-1:0] == reqTag_r);
      end
      hit_s    = 1'b1;
      hitWay_s = 2'd0;
      if (match_s[0]) begin
         hitWay_s = 2'd0;
      end else if (match_s[1]) begin
         hitWay_s = 2'd1;
      end else if (match_s[2]) begin
         hitWay_s = 2'd2;
      end else if (match_s[3]) begin
         hitWay_s = 2'd3;
      end else begin
         hit_s = 1'b0;
      end
   end

   // Next state and all outputs; clear forces idle values and aborts any transfer.
   always_comb begin
      stateNext_s    = state_r;
      cpu.req_ready  = 1'b0;
      cpu.resp_valid = 1'b0;
      cpu.resp_hit   = 1'b0;
      cpu.resp_way   = 2'd0;
      tb_line        = 10'd0;
      tb_tag         = 11'd0;
      tb_way         = 2'd0;
      tb_en_n        = 1'b1;
      tb_we_n        = 1'b1;
      tb_replace     = 1'b0;
      tb_dirty       = 1'b0;
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = 21'd0;
      if (clear) begin
         stateNext_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               cpu.req_ready = 1'b1;
               if (cpu.req_valid) begin
                  tb_en_n     = 1'b0;
                  tb_line     = cpu.req_addr[LINE_LSB +: LINE_W];
                  stateNext_s = LOOKUP;
               end else begin
                  stateNext_s = IDLE;
               end
            end
            LOOKUP: begin
               tb_en_n     = 1'b0;
               tb_line     = reqLine_r;
               stateNext_s = COMPARE;
            end
            COMPARE: begin
               if (hit_s && !reqWrite_r) begin
                  cpu.resp_valid = 1'b1;
                  cpu.resp_hit   = 1'b1;
                  cpu.resp_way   = hitWay_s;
                  stateNext_s    = IDLE;
               end else if (hit_s) begin
                  stateNext_s = UPDATE;
               end else if (victimDirty_s) begin
                  stateNext_s = WRITEBACK;
               end else begin
                  stateNext_s = REFILL;
               end
            end
            WRITEBACK: begin
               mem_req     = 1'b1;
               mem_we      = 1'b1;
               mem_addr    = {victimTag_r, reqLine_r};
               stateNext_s = mem_ack ? REFILL : WRITEBACK;
            end
            REFILL: begin
               mem_req     = 1'b1;
               mem_addr    = {reqTag_r, reqLine_r};
               stateNext_s = mem_ack ? UPDATE : REFILL;
            end
            UPDATE: begin
               tb_en_n     = 1'b0;
               tb_we_n     = 1'b0;
               tb_line     = reqLine_r;
               tb_way      = way_r;
               tb_tag      = reqTag_r;
               tb_replace  = !wasHit_r;
               tb_dirty    = reqWrite_r;
               stateNext_s = RESPOND;
            end
            RESPOND: begin
               cpu.resp_valid = 1'b1;
               cpu.resp_hit   = wasHit_r;
               cpu.resp_way   = way_r;
               stateNext_s    = IDLE;
            end
            default: begin
               stateNext_s = IDLE;
            end
         endcase
      end
   end

   // State, latched request, lookup outcome and statistics.
   always_ff @(posedge CLK) begin
      if (clear) begin
         state_r     <= IDLE;
         reqTag_r    <= 11'd0;
         reqLine_r   <= 10'd0;
         reqWrite_r  <= 1'b0;
         wasHit_r    <= 1'b0;
         way_r       <= 2'd0;
         victimTag_r <= 11'd0;
         hitCount_r  <= 16'd0;
         missCount_r <= 16'd0;
      end else begin
         state_r <= stateNext_s;
         if (state_r == IDLE && cpu.req_valid) begin
            reqTag_r   <= cpu.req_addr[TAG_LSB +: TAG_W];
            reqLine_r  <= cpu.req_addr[LINE_LSB +: LINE_W];
            reqWrite_r <= cpu.req_write;
         end
         if (state_r == COMPARE) begin
            wasHit_r    <= hit_s;
            way_r       <= hit_s ? hitWay_s : victimWay_s;
            victimTag_r <= victimStatus_s[TAG_W-1:0];
            if (hit_s) begin
               hitCount_r <= satInc(hitCount_r, CNT_SAT);
            end else begin
               missCount_r <= satInc(missCount_r, CNT_SAT);
            end
         end
      end
   end
endmodule
